// File: rtl/router_pkg.sv
// Shared types and header field layout for the router output-port drain engine.
package router_pkg;

  localparam int unsigned ADDR_W       = 2;
  localparam int unsigned LEN_W        = 6;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned HDR_ADDR_LSB = 0;
  localparam int unsigned HDR_LEN_LSB  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StHdrWait,
    StBody,
    StDrain
  } state_e;

endpackage

// File: rtl/router_out_port_if.sv
// Payload byte stream (valid/ready with sop/eop framing) leaving a router output port.
interface router_out_port_if;
  import router_pkg::*;

  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_sop;
  logic              m_eop;

  modport master (output m_data, m_valid, m_sop, m_eop, input m_ready);
  modport slave  (input m_data, m_valid, m_sop, m_eop, output m_ready);

endinterface

// File: rtl/router_skid_buf.sv
// Small circular FIFO of {eop, data} entries with an occupancy count; flush empties it.
module router_skid_buf #(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [8:0]      push_data_i,
  input  logic            pop_i,
  output logic [8:0]      pop_data_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [8:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= inc_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= inc_ptr(rd_ptr_q);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/router_out_port.sv
// Drains one router output FIFO into a framed byte stream, checks parity, reports completion.
// Optional ROUTER_OUT_STATS_EN adds packet / error counters.
module router_out_port
  import router_pkg::*;
#(
  parameter int unsigned BUF_DEPTH   = 2,
  parameter int unsigned ABORT_LIMIT = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              vld_out,
  input  logic [DATA_W-1:0] data_out,
  output logic              read_enb,
  router_out_port_if.master strm,
  output logic [ADDR_W-1:0] pkt_addr,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              pkt_done,
  output logic              pkt_err,
  output logic              pkt_abort
`ifdef ROUTER_OUT_STATS_EN
  ,
  output logic [15:0]       stat_pkts,
  output logic [15:0]       stat_errs
`endif
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  state_e            state_q;
  logic [LEN_W:0]    req_left_q;
  logic [LEN_W-1:0]  pay_left_q;
  logic [DATA_W-1:0] acc_q;
  logic [7:0]        idle_cnt_q;
  logic              rd_pend_q, sop_pend_q, bad_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              done_q, err_q, abort_q;

  logic [CntW-1:0]   buf_count;
  logic              buf_empty, beat_valid, pop;
  logic [DATA_W:0]   head;
  logic [LEN_W-1:0]  hdr_len;
  logic              credit_ok, rx, rx_payload, rx_parity, stall, abort_fire;

  assign hdr_len    = data_out[HDR_LEN_LSB +: LEN_W];
  // A read in flight already owns a buffer slot.
  assign credit_ok  = (32'(buf_count) + 32'(rd_pend_q)) < BUF_DEPTH;
  assign rx         = rd_pend_q && (state_q == StBody);
  assign rx_payload = rx && (pay_left_q != '0);
  assign rx_parity  = rx && (pay_left_q == '0);
  assign stall      = ((state_q == StHdrWait) || (state_q == StBody)) && !vld_out && !rd_pend_q;
  assign abort_fire = stall && (idle_cnt_q == 8'(ABORT_LIMIT - 1));

  assign beat_valid   = !buf_empty;
  assign pop          = beat_valid && strm.m_ready;
  assign strm.m_valid = beat_valid;
  assign strm.m_data  = beat_valid ? head[DATA_W-1:0] : '0;
  assign strm.m_eop   = beat_valid && head[DATA_W];
  assign strm.m_sop   = beat_valid && sop_pend_q;

  router_skid_buf #(
    .Depth(BUF_DEPTH)
  ) u_buf (
    .clock      (clock),
    .resetn     (resetn),
    .flush_i    (abort_fire),
    .push_i     (rx_payload),
    .push_data_i({(pay_left_q == LEN_W'(1)), data_out}),
    .pop_i      (pop),
    .pop_data_o (head),
    .empty_o    (buf_empty),
    .count_o    (buf_count)
  );

  always_comb begin
    read_enb = 1'b0;
    unique case (state_q)
      StIdle:  read_enb = vld_out;
      StBody:  read_enb = vld_out && (req_left_q != '0) && credit_ok;
      default: read_enb = 1'b0;
    endcase
    if (!resetn) read_enb = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      req_left_q <= '0;
      pay_left_q <= '0;
      acc_q      <= '0;
      idle_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      sop_pend_q <= 1'b0;
      bad_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
      rd_pend_q  <= read_enb;
      idle_cnt_q <= stall ? idle_cnt_q + 8'd1 : 8'd0;
      if (pop) sop_pend_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (read_enb) state_q <= StHdrWait;
        end
        StHdrWait: begin
          addr_q     <= data_out[HDR_ADDR_LSB +: ADDR_W];
          len_q      <= hdr_len;
          acc_q      <= data_out;
          req_left_q <= {1'b0, hdr_len} + (LEN_W + 1)'(1);
          pay_left_q <= hdr_len;
          sop_pend_q <= 1'b1;
          bad_q      <= (hdr_len == '0);
          state_q    <= StBody;
        end
        StBody: begin
          if (read_enb) req_left_q <= req_left_q - (LEN_W + 1)'(1);
          if (rx_payload) begin
            acc_q      <= acc_q ^ data_out;
            pay_left_q <= pay_left_q - LEN_W'(1);
          end
          if (rx_parity) begin
            bad_q   <= bad_q || (acc_q != data_out);
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (buf_empty) begin
            done_q  <= 1'b1;
            err_q   <= bad_q;
            state_q <= StIdle;
          end
        end
      endcase
      // Upstream went quiet mid-packet: drop buffered beats and report the truncation.
      if (abort_fire) begin
        state_q    <= StIdle;
        idle_cnt_q <= '0;
        sop_pend_q <= 1'b0;
        done_q     <= 1'b1;
        err_q      <= 1'b1;
        abort_q    <= 1'b1;
      end
    end
  end

  assign pkt_addr  = addr_q;
  assign pkt_len   = len_q;
  assign pkt_done  = done_q;
  assign pkt_err   = err_q;
  assign pkt_abort = abort_q;

`ifdef ROUTER_OUT_STATS_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stat_pkts <= '0;
      stat_errs <= '0;
    end else if (done_q) begin
      stat_pkts <= stat_pkts + 16'd1;
      if (err_q) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule
